// File: rtl/design_params_pkg.sv
// rtl/design_params_pkg.sv - shared widths, FSM states and arbitration modes for the register bus
package design_params_pkg;

  localparam int P_NUM_MASTERS = 4;
  localparam int P_ADDR_WIDTH  = 8;
  localparam int P_DATA_WIDTH  = 32;
  localparam int P_ARB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - req/gnt bus bundle between masters, arbiter and slave
interface bus_arbiter_if
  import design_params_pkg::*;
#(
  parameter int NUM_MASTERS = P_NUM_MASTERS,
  parameter int ADDR_WIDTH  = P_ADDR_WIDTH,
  parameter int DATA_WIDTH  = P_DATA_WIDTH
) ();

  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]            m_write_en;
  logic [NUM_MASTERS-1:0]            m_gnt;
  logic [DATA_WIDTH-1:0]             m_rdata;

  logic                              s_req;
  logic [ADDR_WIDTH-1:0]             s_addr;
  logic [DATA_WIDTH-1:0]             s_wdata;
  logic                              s_write_en;
  logic                              s_gnt;
  logic [DATA_WIDTH-1:0]             s_rdata;

  modport master (
    output m_req, m_addr, m_wdata, m_write_en,
    input  m_gnt, m_rdata
  );

  modport slave (
    input  s_req, s_addr, s_wdata, s_write_en,
    output s_gnt, s_rdata
  );

  modport arb (
    input  m_req, m_addr, m_wdata, m_write_en,
    output m_gnt, m_rdata,
    output s_req, s_addr, s_wdata, s_write_en,
    input  s_gnt, s_rdata
  );

endinterface

// File: rtl/bus_arb_picker.sv
// rtl/bus_arb_picker.sv - combinational winner selection, fixed priority or round-robin
module bus_arb_picker
  import design_params_pkg::*;
#(
  parameter  int NUM_MASTERS = P_NUM_MASTERS,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  input  arb_mode_e              mode,
  output logic [IDX_W-1:0]       winner,
  output logic                   valid
);

  // Scan from the highest search offset down so the nearest requester to the start point wins.
  always_comb begin
    int base;
    int idx;
    winner = '0;
    valid  = 1'b0;
    base   = (mode == ARB_RR) ? int'(last) + 1 : 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = (base + k) % NUM_MASTERS;
      if (req[idx]) begin
        winner = IDX_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - N-master req/gnt arbiter; define BUS_ARB_TIMEOUT_EN for the slave-grant watchdog
module bus_arbiter
  import design_params_pkg::*;
#(
  parameter  int                    NUM_MASTERS    = P_NUM_MASTERS,
  parameter  int                    ADDR_WIDTH     = P_ADDR_WIDTH,
  parameter  int                    DATA_WIDTH     = P_DATA_WIDTH,
  parameter  arb_mode_e             ARB_MODE       = ARB_RR,
  parameter  int                    TIMEOUT_CYCLES = P_ARB_TIMEOUT,
  parameter  logic [DATA_WIDTH-1:0] ERR_RDATA      = DATA_WIDTH'(32'hDEAD_BEEF),
  localparam int                    IDX_W          = $clog2(NUM_MASTERS)
) (
  input  logic             clk,
  input  logic             reset,
  bus_arbiter_if.arb       bus,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic             timeout_err
);

  arb_state_e             state_q, state_n;
  logic [IDX_W-1:0]       last_q, last_n, owner_n, pick;
  logic                   pick_valid;
  logic                   s_req_q, s_req_n, s_we_q, s_we_n;
  logic [ADDR_WIDTH-1:0]  s_addr_q, s_addr_n;
  logic [DATA_WIDTH-1:0]  s_wdata_q, s_wdata_n, m_rdata_q, m_rdata_n;
  logic [NUM_MASTERS-1:0] m_gnt_q, m_gnt_n;
  logic                   timeout_hit;

  bus_arb_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req    (bus.m_req),
    .last   (last_q),
    .mode   (ARB_MODE),
    .winner (pick),
    .valid  (pick_valid)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            terr_q;

  // The last BUSY cycle before the limit is the expiry cycle; a grant in it still wins.
  assign timeout_hit = (state_q == BUSY) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts BUSY cycles and restarts whenever the FSM is outside BUSY.
  always_ff @(posedge clk) begin
    if (reset || state_q != BUSY) wd_q <= '0;
    else                          wd_q <= wd_q + WD_W'(1);
  end

  // Error flag pulses together with the gnt of an aborted transaction.
  always_ff @(posedge clk) begin
    if (reset) terr_q <= 1'b0;
    else       terr_q <= timeout_hit && !bus.s_gnt;
  end

  assign timeout_err = terr_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and next-register values; requests only matter in IDLE, s_gnt only in BUSY.
  always_comb begin
    state_n   = state_q;
    last_n    = last_q;
    owner_n   = owner;
    s_req_n   = s_req_q;
    s_addr_n  = s_addr_q;
    s_wdata_n = s_wdata_q;
    s_we_n    = s_we_q;
    m_rdata_n = m_rdata_q;
    m_gnt_n   = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          s_req_n   = 1'b1;
          s_addr_n  = bus.m_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          s_wdata_n = bus.m_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          s_we_n    = bus.m_write_en[pick];
          owner_n   = pick;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        if (bus.s_gnt || timeout_hit) begin
          m_rdata_n      = bus.s_gnt ? bus.s_rdata : ERR_RDATA;
          s_req_n        = 1'b0;
          m_gnt_n[owner] = 1'b1;
          last_n         = owner;
          state_n        = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction without a gnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= IDX_W'(NUM_MASTERS - 1);
      owner     <= '0;
      s_req_q   <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_we_q    <= 1'b0;
      m_rdata_q <= '0;
      m_gnt_q   <= '0;
    end else begin
      state_q   <= state_n;
      last_q    <= last_n;
      owner     <= owner_n;
      s_req_q   <= s_req_n;
      s_addr_q  <= s_addr_n;
      s_wdata_q <= s_wdata_n;
      s_we_q    <= s_we_n;
      m_rdata_q <= m_rdata_n;
      m_gnt_q   <= m_gnt_n;
    end
  end

  assign bus.s_req      = s_req_q;
  assign bus.s_addr     = s_addr_q;
  assign bus.s_wdata    = s_wdata_q;
  assign bus.s_write_en = s_we_q;
  assign bus.m_gnt      = m_gnt_q;
  assign bus.m_rdata    = m_rdata_q;
  assign busy           = (state_q != IDLE);

endmodule
